// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: register-index width, x0 constant and hazard FSM encoding.
package hazard_unit_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-detection bundle between the pipeline datapath and the stall/flush controller.
interface hazard_unit_if #(parameter int CNT_W = 16);
   import hazard_unit_pkg::*;

   logic [REG_W-1:0] rs1D;
   logic [REG_W-1:0] rs2D;
   logic [REG_W-1:0] rdE;
   logic             memReadE;
   logic             pcSrcE;
   logic             memReqM;
   logic             memReadyM;
   logic             stallF;
   logic             stallD;
   logic             stallE;
   logic             stallM;
   logic             flushD;
   logic             flushE;
   logic             flushW;
   logic [CNT_W-1:0] stallCount;
   logic [CNT_W-1:0] flushCount;
   logic             memTimeout;

   modport master (
      output rs1D, rs2D, rdE, memReadE, pcSrcE, memReqM, memReadyM,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
      input  stallCount, flushCount, memTimeout
   );

   modport slave (
      input  rs1D, rs2D, rdE, memReadE, pcSrcE, memReqM, memReadyM,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
      output stallCount, flushCount, memTimeout
   );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the hazard performance counters.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken-branch and data-memory-wait hazards.
//
// state       | meaning
// ST_RUN      | no outstanding data-memory wait; waitCnt held at zero
// ST_MEM_WAIT | MEM access stretched by memReadyM low; waitCnt counts toward timeout
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hu
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_timeout;
   logic              load_use, mem_busy;
   logic              stall_f, stall_d, stall_e, stall_m;
   logic              flush_d, flush_e, flush_w;

   always_comb begin
      load_use = hu.memReadE && (hu.rdE != REG_ZERO) &&
                 ((hu.rdE == hu.rs1D) || (hu.rdE == hu.rs2D));
      mem_busy = hu.memReqM && !hu.memReadyM;
   end

   // EX is frozen during a memory wait, so branch and load-use are re-evaluated afterwards
   always_comb begin
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_w   = 1'b0;
      state_nxt = state;
      if (!reset) begin
         if (mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (hu.pcSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
      case (state)
         ST_RUN:      if (mem_busy) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (hu.memReadyM || !hu.memReqM) state_nxt = ST_RUN;
         default:     state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   // Timeout only flags the hang; the pipeline stays frozen until the memory answers or reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (state == ST_RUN) begin
         wait_cnt <= '0;
      end else if (mem_busy && (wait_cnt != WAIT_MAX)) begin
         wait_cnt <= wait_cnt + 1'b1;
         if (wait_cnt == WAIT_LAST)
            mem_timeout <= 1'b1;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_f),
      .clear (1'b0),
      .count (hu.stallCount)
   );

   // flush_d is unique to the branch case, so load-use bubbles are not counted
   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_d),
      .clear (1'b0),
      .count (hu.flushCount)
   );

   assign hu.stallF     = stall_f;
   assign hu.stallD     = stall_d;
   assign hu.stallE     = stall_e;
   assign hu.stallM     = stall_m;
   assign hu.flushD     = flush_d;
   assign hu.flushE     = flush_e;
   assign hu.flushW     = flush_w;
   assign hu.memTimeout = mem_timeout;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus randomized traffic against a rule-level model.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_unit_if #(.CNT_W(CNT_W)) hif ();

   hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hu    (hif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model state: counters, consecutive busy cycles, sticky timeout
   int m_stall  = 0;
   int m_flush  = 0;
   int m_streak = 0;
   bit m_to     = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
   function automatic logic [6:0] dut_ctl();
      return {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.flushD, hif.flushE, hif.flushW};
   endfunction

   function automatic logic [6:0] exp_ctl();
      bit busy, lu;
      busy = hif.memReqM && !hif.memReadyM;
      lu   = hif.memReadE && (hif.rdE != 0) && ((hif.rdE == hif.rs1D) || (hif.rdE == hif.rs2D));
      if (busy)            return 7'b1111_001;
      else if (hif.pcSrcE) return 7'b0000_110;
      else if (lu)         return 7'b1100_010;
      else                 return 7'b0000_000;
   endfunction

   function automatic void model_reset();
      m_stall  = 0;
      m_flush  = 0;
      m_streak = 0;
      m_to     = 1'b0;
   endfunction

   // flags = {memReadE, pcSrcE, memReqM, memReadyM}; entered and left on a falling edge
   task automatic cyc(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [3:0] flags);
      logic [6:0] e;
      hif.rs1D      = r1;
      hif.rs2D      = r2;
      hif.rdE       = rd;
      hif.memReadE  = flags[3];
      hif.pcSrcE    = flags[2];
      hif.memReqM   = flags[1];
      hif.memReadyM = flags[0];
      #1;
      e = exp_ctl();
      check({tag, "/ctl"},        32'(dut_ctl()),        32'(e));
      check({tag, "/stallCount"}, 32'(hif.stallCount),   32'(m_stall));
      check({tag, "/flushCount"}, 32'(hif.flushCount),   32'(m_flush));
      check({tag, "/memTimeout"}, 32'(hif.memTimeout),   32'(m_to));
      @(posedge clk);
      if (e[6] && m_stall < CNT_MAX) m_stall++;
      if (e[2] && m_flush < CNT_MAX) m_flush++;
      if (flags[1] && !flags[0]) m_streak++;
      else                       m_streak = 0;
      // first busy cycle is spent entering the wait; timeout after MEM_TIMEOUT further ones
      if (m_streak >= MEM_TIMEOUT + 1) m_to = 1'b1;
      @(negedge clk);
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      check({tag, "/ctl"},        32'(dut_ctl()),      32'd0);
      check({tag, "/stallCount"}, 32'(hif.stallCount), 32'd0);
      check({tag, "/flushCount"}, 32'(hif.flushCount), 32'd0);
      check({tag, "/memTimeout"}, 32'(hif.memTimeout), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      hif.rs1D      = 5'd3;
      hif.rs2D      = 5'd0;
      hif.rdE       = 5'd3;
      hif.memReadE  = 1'b1;
      hif.pcSrcE    = 1'b1;
      hif.memReqM   = 1'b1;
      hif.memReadyM = 1'b0;
      #1;
      check("rst/ctl",        32'(dut_ctl()),      32'd0);
      check("rst/stallCount", 32'(hif.stallCount), 32'd0);
      check("rst/flushCount", 32'(hif.flushCount), 32'd0);
      check("rst/memTimeout", 32'(hif.memTimeout), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // load-use bubble, then clear
      cyc("lu",      5'd5, 5'd0, 5'd5, 4'b1000);
      cyc("lu_next", 5'd5, 5'd0, 5'd5, 4'b0000);
      check("lu/stall_one", 32'(hif.stallCount), 32'd1);

      // branch wins over a simultaneous load-use
      cyc("br_lu", 5'd0, 5'd7, 5'd7, 4'b1100);
      check("br_lu/flush_one", 32'(hif.flushCount), 32'd1);
      check("br_lu/stall_same", 32'(hif.stallCount), 32'd1);

      // three wait cycles with a pending branch, then ready
      for (int i = 0; i < 3; i++) cyc("mwait", 5'd0, 5'd0, 5'd0, 4'b0110);
      cyc("mwait_done", 5'd0, 5'd0, 5'd0, 4'b0111);
      cyc("mwait_idle", 5'd0, 5'd0, 5'd0, 4'b0000);
      check("mwait/stall_plus3", 32'(hif.stallCount), 32'd4);

      // timeout, sticky through ready and idle traffic
      for (int i = 0; i < 6; i++) cyc("tmo", 5'd1, 5'd2, 5'd3, 4'b0010);
      check("tmo/set", 32'(hif.memTimeout), 32'd1);
      cyc("tmo_ready", 5'd1, 5'd2, 5'd3, 4'b0011);
      for (int i = 0; i < 3; i++) cyc("tmo_idle", 5'd1, 5'd2, 5'd3, 4'b0000);
      check("tmo/sticky", 32'(hif.memTimeout), 32'd1);

      // saturation of the stall counter
      for (int i = 0; i < 20; i++) cyc("sat", 5'd9, 5'd9, 5'd9, 4'b1000);
      check("sat/stall_max", 32'(hif.stallCount), 32'(CNT_MAX));

      // asynchronous reset in the middle of a wait, then a fresh wait must restart the timeout
      cyc("rw_busy", 5'd0, 5'd0, 5'd0, 4'b0010);
      cyc("rw_busy", 5'd0, 5'd0, 5'd0, 4'b0010);
      async_reset("rw_reset");
      for (int i = 0; i < MEM_TIMEOUT; i++) cyc("rw_after", 5'd0, 5'd0, 5'd0, 4'b0010);
      check("rw/no_timeout", 32'(hif.memTimeout), 32'd0);
      cyc("rw_ready", 5'd0, 5'd0, 5'd0, 4'b0011);

      // x0 destination never stalls
      cyc("zero", 5'd0, 5'd0, 5'd0, 4'b1000);
      check("zero/no_stall", 32'(hif.stallF), 32'd0);

      // randomized traffic with narrow register range for frequent matches
      for (int i = 0; i < 500; i++) begin
         logic [3:0] f;
         f[3] = 1'($urandom_range(0, 1));
         f[2] = ($urandom_range(0, 3) == 0);
         f[1] = ($urandom_range(0, 2) != 0);
         f[0] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 63) == 0)
            async_reset("rnd_reset");
         else
            cyc("rnd", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
